div_seq_unit: RTL

DIV_SEQ_UNIT -- requirements
Module: div_seq_unit

---
 rtl/div_pkg.sv | 5 +
 rtl/div_step.sv | 15 +
 rtl/div_seq_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared width constant and divider state encoding
package div_pkg;
    localparam int WIDTH = 32;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one non-restoring iteration on a sign-extended partial remainder
module div_step import div_pkg::*; #(
    parameter int W = WIDTH
) (
    input  logic [W:0]   a,
    input  logic         bit_in,
    input  logic [W-1:0] d,
    output logic [W:0]   new_a,
    output logic         q
);
    logic [W:0] a_sh;
    assign a_sh  = {a[W-1:0], bit_in};
    assign new_a = a[W] ? a_sh + {1'b0, d} : a_sh - {1'b0, d};
    assign q     = ~new_a[W];
endmodule

// File: rtl/div_seq_unit.sv
// div_seq_unit: 32-step sequential signed/unsigned divider with fix-up and divide-by-zero bypass
module div_seq_unit import div_pkg::*; #(
    parameter int WIDTH = div_pkg::WIDTH
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iDividend,
    input  logic [WIDTH-1:0] iDivisor,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oQ,
    output logic [WIDTH-1:0] oR,
    output logic             oDivZero
);
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    // one extra bit keeps the partial remainder exact for unsigned divisors >= 2^(WIDTH-1)
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   new_a;
    logic [WIDTH-1:0] q_sr;
    logic [WIDTH-1:0] d;
    logic             q_neg;
    logic             r_neg;
    logic             q_bit;
    logic [WIDTH:0]   r_fix;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] r_out;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    div_step #(.W(WIDTH)) u_step (
        .a(a),
        .bit_in(q_sr[WIDTH-1]),
        .d(d),
        .new_a(new_a),
        .q(q_bit)
    );

    always_comb begin
        r_fix = a[WIDTH] ? a + {1'b0, d} : a;
        q_out = q_neg ? -q_sr : q_sr;
        r_out = r_neg ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
    end

    assign oBusy = state != IDLE;
    assign oDone = state == DONE;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= IDLE;
            cnt      <= '0;
            a        <= '0;
            q_sr     <= '0;
            d        <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            oQ       <= '0;
            oR       <= '0;
            oDivZero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (iStart) begin
                    if (iDivisor == '0) begin
                        state    <= DONE;
                        oQ       <= '1;
                        oR       <= iDividend;
                        oDivZero <= 1'b1;
                    end else begin
                        state <= RUN;
                        cnt   <= '0;
                        a     <= '0;
                        q_sr  <= mag(iDividend, iSigned);
                        d     <= mag(iDivisor, iSigned);
                        q_neg <= iSigned & (iDividend[WIDTH-1] ^ iDivisor[WIDTH-1]);
                        r_neg <= iSigned & iDividend[WIDTH-1];
                    end
                end
                RUN: begin
                    a     <= new_a;
                    q_sr  <= {q_sr[WIDTH-2:0], q_bit};
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CW'(WIDTH-1)) ? FIX : RUN;
                end
                FIX: begin
                    oQ       <= q_out;
                    oR       <= r_out;
                    oDivZero <= 1'b0;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
